// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store byte enables / lane replication,
// and load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic        o_fault,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [31:0]        w_shifted;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  // Unsigned sizes are load-only; the three unused codes are always illegal.
  always_comb begin
    o_fault = 1'b1;
    case (i_funct3)
      F3_B:    o_fault = 1'b0;
      F3_BU:   o_fault = i_we;
      F3_H:    o_fault = i_off[0];
      F3_HU:   o_fault = i_we | i_off[0];
      F3_W:    o_fault = |i_off;
      default: o_fault = 1'b1;
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be    = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_shifted = i_ld_word >> {i_ld_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_funct3)
      F3_B:    o_ld_data = 32'(w_byte);
      F3_BU:   o_ld_data = {24'h000000, w_shifted[7:0]};
      F3_H:    o_ld_data = 32'(w_half);
      F3_HU:   o_ld_data = {16'h0000, w_shifted[15:0]};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: drives one req/gnt/rvalid transaction per load/store and
// stalls the core until it completes, aborting with bus_err on a stuck bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic [31:0]      r_rdata;
  logic [31:0]      r_dm_addr;
  logic [3:0]       r_dm_be;
  logic [31:0]      r_dm_wdata;
  logic             r_bus_err;

  logic             w_fault_cond;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ld_data;
  logic             w_accept;
  logic             w_timeout;

  lsu_align u_align (
    .i_we        (lsu_we),
    .i_funct3    (funct3),
    .i_off       (addr[1:0]),
    .i_wdata     (wdata),
    .i_ld_funct3 (r_f3),
    .i_ld_off    (r_off),
    .i_ld_word   (dm_rdata),
    .o_fault     (w_fault_cond),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_ld_data   (w_ld_data)
  );

  assign fault    = lsu_req & w_fault_cond;
  assign w_accept = (r_state == S_IDLE) & lsu_req & ~w_fault_cond;

  // Next state and per-state outputs; the abort cycle already drops the request.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    dm_req    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = S_ADDR;
      end
      S_ADDR: begin
        stall     = 1'b1;
        w_timeout = (r_cnt == CNT_LAST);
        dm_req    = ~w_timeout;
        if (w_timeout)   w_next = S_DONE;
        else if (dm_gnt) w_next = r_we ? S_DONE : S_RESP;
      end
      S_RESP: begin
        stall     = 1'b1;
        w_timeout = (r_cnt == CNT_LAST);
        if (w_timeout || dm_rvalid) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_f3       <= F3_B;
      r_off      <= 2'b00;
      r_rdata    <= '0;
      r_dm_addr  <= '0;
      r_dm_be    <= '0;
      r_dm_wdata <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_we       <= lsu_we;
            r_f3       <= funct3;
            r_off      <= addr[1:0];
            r_dm_addr  <= {addr[31:2], 2'b00};
            r_dm_be    <= w_be;
            r_dm_wdata <= lsu_we ? w_wdata : '0;
          end
        end
        S_ADDR, S_RESP: begin
          if (w_timeout) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == S_RESP) && dm_rvalid) r_rdata <= w_ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign bus_err  = r_bus_err;
  assign dm_we    = r_we & dm_req;
  assign dm_addr  = r_dm_addr;
  assign dm_be    = r_dm_be;
  assign dm_wdata = r_dm_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a behavioural reference model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        lsu_req   = 1'b0;
  logic        lsu_we    = 1'b0;
  logic [2:0]  funct3    = 3'b000;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic        dm_gnt    = 1'b0;
  logic        dm_rvalid = 1'b0;
  logic [31:0] dm_rdata  = '0;
  logic        stall, fault, bus_err, dm_req, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  int n_chk  = 0;
  int n_fail = 0;

  bit          in_txn = 1'b0;
  int          scyc   = 0;
  logic [31:0] exp_addr, exp_wd, exp_rdata;
  logic [3:0]  exp_be;
  bit          exp_we, exp_berr, exp_chk_rd;
  int          exp_stall;
  logic        seen_fault, seen_stall, seen_req;

  logic [2:0] st_f3s [3] = '{3'b000, 3'b001, 3'b010};
  logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .fault     (fault),
    .bus_err   (bus_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_be     (dm_be),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic m_fault(input logic req, input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    if (!req)          return 1'b0;
    if (sz == 0)       return 1'b1;
    if (we && f3[2])   return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << m_size(f3)) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wd(input logic we, input logic [2:0] f3, input logic [31:0] wd);
    if (!we) return 32'h0;
    case (m_size(f3))
      1:       return 32'(wd[7:0]) * 32'h01010101;
      2:       return 32'(wd[15:0]) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * int'(a[1:0]));
    case (m_size(f3))
      1: begin
        v = v & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = v & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("fault", 32'(fault), 32'(m_fault(lsu_req, lsu_we, funct3, addr)));
      if (dm_req) begin
        chk("dm_addr", dm_addr, exp_addr);
        chk("dm_be", 32'(dm_be), 32'(exp_be));
        chk("dm_we", 32'(dm_we), 32'(exp_we));
        chk("dm_wdata", dm_wdata, exp_wd);
      end
      if (in_txn) begin
        if (stall) begin
          scyc++;
          chk("bus_err_busy", 32'(bus_err), 32'd0);
        end else begin
          chk("stall_cycles", 32'(scyc), 32'(exp_stall));
          chk("bus_err_done", 32'(bus_err), 32'(exp_berr));
          if (exp_chk_rd) chk("rdata", rdata, exp_rdata);
          in_txn = 1'b0;
          scyc   = 0;
        end
      end else begin
        scyc = 0;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_dm_req", 32'(dm_req), 32'd0);
        chk("idle_bus_err", 32'(bus_err), 32'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rvd, input bit no_rv);
    int need, gcnt, rcnt, cyc;
    bit granted, rv_done, done;
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = wd;
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    need       = we ? gd + 1 : (no_rv ? 1000 : gd + rvd + 2);
    exp_addr   = a & ~32'h3;
    exp_be     = m_be(f3, a);
    exp_we     = we;
    exp_wd     = m_wd(we, f3, wd);
    exp_berr   = (need > TO - 1);
    exp_stall  = exp_berr ? TO + 1 : need + 1;
    exp_rdata  = exp_berr ? 32'h0 : m_ld(f3, a, rd);
    exp_chk_rd = !we || exp_berr;
    in_txn     = 1'b1;
    gcnt = 0; rcnt = 0; cyc = 0; granted = 1'b0; rv_done = 1'b0; done = 1'b0;
    #3;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      if (dm_req) begin
        if (gcnt == gd) begin
          dm_gnt  = 1'b1;
          granted = 1'b1;
        end else begin
          gcnt++;
          dm_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (granted && !we && !no_rv && !rv_done) begin
        if (rcnt == rvd) begin
          dm_rvalid = 1'b1;
          dm_rdata  = rd;
          rv_done   = 1'b1;
        end else begin
          rcnt++;
        end
      end
      #3;
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_bound: stall still %0d after %0d cycles, expected release", stall, cyc);
      in_txn  = 1'b0;
      lsu_req = 1'b0;
    end
  endtask

  task automatic run_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = $urandom;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; in_txn = 1'b0;
    #3;
    seen_fault = fault; seen_stall = stall; seen_req = dm_req;
    @(negedge clk);
    #3;
    seen_req = seen_req | dm_req;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lsu_req = 1'b0; lsu_we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom;
      dm_gnt = 1'($urandom); dm_rvalid = 1'($urandom); dm_rdata = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          sel, sz;
    bit          to;

    #1 rst_n = 1'b0;
    #11;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_be", 32'(dm_be), 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed values that pin the model.
    chk("pin_sb_be", 32'(m_be(3'b000, 32'h103)), 32'h8);
    chk("pin_sb_wd", m_wd(1'b1, 3'b000, 32'hAB), 32'hABABABAB);
    chk("pin_lb", m_ld(3'b000, 32'h202, 32'h00800000), 32'hFFFFFF80);
    chk("pin_lbu", m_ld(3'b100, 32'h202, 32'h00800000), 32'h00000080);
    chk("pin_lh_fault", 32'(m_fault(1'b1, 1'b0, 3'b001, 32'h201)), 32'd1);
    chk("pin_sw_fault", 32'(m_fault(1'b1, 1'b1, 3'b010, 32'h302)), 32'd1);

    // Directed cases.
    run_access(1'b1, 3'b000, 32'h103, 32'hAB, 32'h0, 0, 0, 1'b0);
    chk("t1_stall_model", 32'(exp_stall), 32'd2);
    chk("t1_be", 32'(dm_be), 32'h8);
    chk("t1_wdata", dm_wdata, 32'hABABABAB);
    chk("t1_addr", dm_addr, 32'h100);
    run_access(1'b0, 3'b000, 32'h202, 32'h0, 32'h00800000, 0, 0, 1'b0);
    chk("t2_stall_model", 32'(exp_stall), 32'd3);
    chk("t2_lb", rdata, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h202, 32'h0, 32'h00800000, 0, 0, 1'b0);
    chk("t2_lbu", rdata, 32'h00000080);
    run_fault(1'b0, 3'b001, 32'h201);
    chk("t3_lh_fault", 32'(seen_fault), 32'd1);
    chk("t3_lh_stall", 32'(seen_stall), 32'd0);
    chk("t3_lh_req", 32'(seen_req), 32'd0);
    run_fault(1'b1, 3'b010, 32'h302);
    chk("t3_sw_fault", 32'(seen_fault), 32'd1);
    run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 3, 0, 1'b0);
    chk("t4_lw", rdata, 32'h12345678);
    run_access(1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 0, 1'b1);
    chk("t5_berr", 32'(bus_err), 32'd1);
    chk("t5_rdata", rdata, 32'h0);
    idle(1);
    #3;
    chk("t5_berr_pulse", 32'(bus_err), 32'd0);
    run_access(1'b1, 3'b010, 32'h48, 32'h55AA55AA, 32'h0, 99, 0, 1'b0);
    chk("t5_store_berr", 32'(bus_err), 32'd1);

    // Reset while waiting for read data.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h80;
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
    exp_addr = 32'h80; exp_be = 4'hF; exp_we = 1'b0; exp_wd = 32'h0; exp_berr = 1'b0;
    in_txn = 1'b1;
    @(negedge clk);
    dm_gnt = dm_req;
    @(negedge clk);
    dm_gnt = 1'b0;
    #1 rst_n = 1'b0; in_txn = 1'b0; lsu_req = 1'b0;
    #1;
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_dm_req", 32'(dm_req), 32'd0);
    chk("t6_bus_err", 32'(bus_err), 32'd0);
    chk("t6_dm_addr", dm_addr, 32'h0);
    chk("t6_dm_be", 32'(dm_be), 32'h0);
    chk("t6_rdata", rdata, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    dm_rvalid = 1'b1; dm_gnt = 1'b1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dm_rvalid = 1'b0; dm_gnt = 1'b0;
    #3;
    chk("t6_late_rvalid", rdata, 32'h0);
    run_access(1'b0, 3'b010, 32'h80, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0);
    chk("t6_lw_after", rdata, 32'hCAFEF00D);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      sel  = $urandom_range(0, 9);
      r_a  = $urandom;
      r_we = 1'($urandom);
      if (sel < 2) begin
        r_f3 = 3'($urandom);
        if (m_fault(1'b1, r_we, r_f3, r_a)) run_fault(r_we, r_f3, r_a);
        else run_access(r_we, r_f3, r_a, $urandom, $urandom,
                        $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
      end else if (sel == 2) begin
        idle($urandom_range(1, 3));
      end else begin
        r_f3 = r_we ? st_f3s[$urandom_range(0, 2)] : ld_f3s[$urandom_range(0, 4)];
        sz   = m_size(r_f3);
        r_a  = r_a & ~32'(sz - 1);
        to   = ($urandom_range(0, 29) == 0);
        run_access(r_we, r_f3, r_a, $urandom, $urandom,
                   (to && r_we) ? 99 : $urandom_range(0, 4),
                   $urandom_range(0, 4), to && !r_we);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
